// File: rtl/lane_compositor.sv
// -----------------------------------------------------------------------------
// lane_compositor
//
// Purpose:
//   Composites the rhythm-game playfield over a background pixel stream.
//   It supports NUM_LANES lanes of configurable geometry. For each scan
//   position it selects the judgement line, the border columns, the key area,
//   a note, the lane track, or the background. The selection runs through a
//   2-stage pipeline: the 12-bit colour appears exactly 2 clk after its x/y.
//   Each lane has an 8-bit hit-flash timer. A key press loads the timer with
//   FLASH_FRAMES, and frame_tick decrements it by one per frame.
//
// Optional feature (macro LANE_PALETTE_EN):
//   When defined, notes are red (12'hF00) in even lanes and blue (12'h00F)
//   in odd lanes. When undefined, every note is red. Geometry and timing do
//   not change between the two builds.
//
// Ports:
//   clk         pixel clock
//   rst         asynchronous, active-low reset
//   x, y        scan column / row
//   frame_tick  one-cycle pulse per frame; decays the flash timers
//   keys        per-lane key held (already synchronised to clk)
//   tracks      per-lane note bitmaps, lane i at [i*TRACK_H +: TRACK_H]
//   bg_color    background pixel
//   bg_active   background pixel valid
//   color       composited pixel (registered)
//   in_play     pixel lies inside the playfield span (registered)
// -----------------------------------------------------------------------------
module lane_compositor #(
    parameter int NUM_LANES    = 4,
    parameter int LANE_W       = 100,
    parameter int BORDER_W     = 6,
    parameter int X0           = 50,
    parameter int JUDGE_Y      = 440,
    parameter int LINE_H       = 6,
    parameter int TRACK_H      = 480,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [9:0]                   x,
    input  logic [8:0]                   y,
    input  logic                         frame_tick,
    input  logic [NUM_LANES-1:0]         keys,
    input  logic [NUM_LANES*TRACK_H-1:0] tracks,
    input  logic [11:0]                  bg_color,
    input  logic                         bg_active,
    output logic [11:0]                  color,
    output logic                         in_play
);

    localparam int P  = LANE_W + BORDER_W;
    localparam int XE = X0 + NUM_LANES * P + BORDER_W - 1;
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

    // The judgement line and the borders share the same colour, so both map
    // to one class. R_TRACK covers the inner lane above the judgement line.
    // note_reg decides between note and track colour in stage 2.
    typedef enum logic [1:0] {
        R_OUT   = 2'd0,
        R_WHITE = 2'd1,
        R_KEY   = 2'd2,
        R_TRACK = 2'd3
    } region_t;

    // Widen the scan position once so that every comparison against the
    // integer geometry constants is a plain 32-bit unsigned compare.
    logic [31:0] x_ext;
    logic [31:0] y_ext;
    assign x_ext = {22'd0, x};
    assign y_ext = {23'd0, y};

    logic [NUM_LANES:0]   border_hit;
    logic [NUM_LANES-1:0] inner_hit;
    logic [NUM_LANES-1:0] note_bits;

    genvar gi;
    generate
        for (gi = 0; gi <= NUM_LANES; gi++) begin : g_border
            assign border_hit[gi] = (x_ext >= X0 + gi * P) &&
                                    (x_ext <= X0 + gi * P + BORDER_W - 1);
        end
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [TRACK_H-1:0] lane_bits;
            assign lane_bits      = tracks[gi*TRACK_H +: TRACK_H];
            assign inner_hit[gi]  = (x_ext >= X0 + gi * P + BORDER_W) &&
                                    (x_ext <= X0 + (gi + 1) * P - 1);
            // The row guards come first, so rows past the bitmap never read it.
            assign note_bits[gi]  = (y_ext < TRACK_H) && (y_ext < JUDGE_Y) &&
                                    lane_bits[y];
        end
    endgenerate

    // Flash timers and registered key copy.
    logic [NUM_LANES-1:0] key_q;
    logic [7:0]           flash_cnt [NUM_LANES];

    // The inner-lane hits are one-hot, so OR-reducing the masked per-lane bits
    // selects the current lane's attributes without a wide index mux.
    logic [LW-1:0] lane_sel;
    logic          key_sel;
    logic          flash_sel;
    logic          note_sel;

    always_comb begin
        lane_sel  = '0;
        key_sel   = 1'b0;
        flash_sel = 1'b0;
        note_sel  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (inner_hit[i]) begin
                lane_sel = LW'(i);
            end
            key_sel   = key_sel   | (inner_hit[i] & keys[i]);
            flash_sel = flash_sel | (inner_hit[i] & (flash_cnt[i] != 8'd0));
            note_sel  = note_sel  | (inner_hit[i] & note_bits[i]);
        end
    end

    logic    in_span;
    logic    judge_rows;
    logic    key_rows;
    region_t region_next;

    assign in_span    = (x_ext >= X0) && (x_ext <= XE);
    assign judge_rows = (y_ext >= JUDGE_Y) && (y_ext < JUDGE_Y + LINE_H);
    assign key_rows   = (y_ext >= JUDGE_Y + LINE_H);

    always_comb begin
        region_next = R_OUT;
        if (in_span && judge_rows) begin
            region_next = R_WHITE;
        end else if (|border_hit) begin
            region_next = R_WHITE;
        end else if (|inner_hit) begin
            region_next = key_rows ? R_KEY : R_TRACK;
        end
    end

    // Stage 1: classify the pixel.
    region_t       region_reg;
    logic [LW-1:0] lane_reg;
    logic          note_reg;
    logic          key_reg;
    logic          flash_reg;
    logic          span_reg;
    logic [11:0]   bg_color_reg;
    logic          bg_active_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            region_reg    <= R_OUT;
            lane_reg      <= '0;
            note_reg      <= 1'b0;
            key_reg       <= 1'b0;
            flash_reg     <= 1'b0;
            span_reg      <= 1'b0;
            bg_color_reg  <= 12'h000;
            bg_active_reg <= 1'b0;
        end else begin
            region_reg    <= region_next;
            lane_reg      <= lane_sel;
            note_reg      <= note_sel;
            key_reg       <= key_sel;
            flash_reg     <= flash_sel;
            span_reg      <= in_span;
            bg_color_reg  <= bg_color;
            bg_active_reg <= bg_active;
        end
    end

    // Stage 2: resolve the class to a colour.
    logic [11:0] note_col;
    logic [11:0] color_next;
    logic        unused_lane;

    // Only the parity of the lane index matters, and only for the palette.
    assign unused_lane = ^lane_reg;

`ifdef LANE_PALETTE_EN
    assign note_col = lane_reg[0] ? 12'h00F : 12'hF00;
`else
    assign note_col = 12'hF00;
`endif

    always_comb begin
        color_next = 12'h000;
        case (region_reg)
            R_WHITE: color_next = 12'hFFF;
            R_KEY:   color_next = flash_reg ? 12'h0FF :
                                  (key_reg ? 12'h777 : 12'h444);
            R_TRACK: color_next = note_reg ? note_col :
                                  (key_reg ? 12'h777 : 12'h000);
            default: color_next = bg_active_reg ? bg_color_reg : 12'h000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color   <= 12'h000;
            in_play <= 1'b0;
        end else begin
            color   <= color_next;
            in_play <= span_reg;
        end
    end

    // Flash timers. A rising key edge takes priority over the frame decay,
    // and a key held across cycles produces no further rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                flash_cnt[i] <= 8'd0;
            end
        end else begin
            key_q <= keys;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (keys[i] && !key_q[i]) begin
                    flash_cnt[i] <= FLASH_LOAD;
                end else if (frame_tick && (flash_cnt[i] != 8'd0)) begin
                    flash_cnt[i] <= flash_cnt[i] - 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/lane_compositor.md
Name: lane_compositor

Overview:
- Parametrised successor of the 4-key playfield pixel generator. Supports N lanes with configurable geometry.
- Takes the VGA scan position, lane note bitmaps, key states and a background pixel, and produces a registered 12-bit colour.
- Adds what the fixed version lacks: a 2-stage pipelined pixel path, and a per-lane hit-flash timer triggered on key press and decayed once per frame.
- Sits between the note/track generator and vgac, in place of the fixed 4-lane display logic.

Parameters:
- NUM_LANES, 4, number of lanes (1..8).
- LANE_W, 100, inner lane width in pixels.
- BORDER_W, 6, border width in pixels.
- X0, 50, x of the left edge of the leftmost border.
- JUDGE_Y, 440, first row of the judgement line.
- LINE_H, 6, judgement line height in rows.
- TRACK_H, 480, rows per lane bitmap. Must satisfy TRACK_H >= JUDGE_Y.
- FLASH_FRAMES, 8, frames a hit-flash lasts (1..255).

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  asynchronous, active-low reset.
- x  in  10  scan column.
- y  in  9  scan row.
- frame_tick  in  1  one-cycle pulse per frame.
- keys  in  NUM_LANES  key held per lane (bit i = lane i). Already synchronised to clk.
- tracks  in  NUM_LANES*TRACK_H  note bitmaps. Lane i occupies [i*TRACK_H +: TRACK_H]; a bit indexed by y set means a note at that row.
- bg_color  in  12  background pixel.
- bg_active  in  1  background pixel is valid.
- color  out  12  composited pixel.
- in_play  out  1  pixel lies within the playfield span.

Behaviour:
- Geometry:
  - Border k (k = 0..NUM_LANES) spans X0+k*P .. X0+k*P+BORDER_W-1, where P = LANE_W+BORDER_W.
  - Lane i inner spans X0+i*P+BORDER_W .. X0+(i+1)*P-1.
  - Playfield span: X0 .. XE, where XE = X0+NUM_LANES*P+BORDER_W-1.
- Lane index is computed by a comparator chain; no divider.
- Pixel priority, first match wins:
  1. Judgement line: X0<=x<=XE and JUDGE_Y<=y<JUDGE_Y+LINE_H → 12'hFFF.
  2. Border column, any y → 12'hFFF.
  3. Key area: inner lane i, y>=JUDGE_Y+LINE_H → 12'h0FF if flash_cnt[i]!=0, else 12'h777 if keys[i], else 12'h444.
  4. Note: inner lane i, y<JUDGE_Y, y<TRACK_H, bitmap bit set → note colour (12'hF00).
  5. Track: inner lane i → 12'h777 if keys[i], else 12'h000.
  6. Outside playfield: bg_color if bg_active, else 12'h000.
- Pipeline:
  - Stage 1 registers the region class, lane index, note bit, and the key and flash bits.
  - Stage 2 registers color and in_play.
  - Latency is exactly 2 clk from x/y to color. Throughput is one pixel per clk. No stall.
- Flash timer, per lane, 8-bit flash_cnt[i]:
  - key_q[i] is the registered copy of keys[i]. A rise is keys[i] & ~key_q[i].
  - On a rise, load FLASH_FRAMES.
  - Otherwise, on frame_tick with flash_cnt[i]!=0, decrement by 1. It saturates at 0.
  - Rise and frame_tick in the same cycle: load wins, no decrement.
  - A held key does not reload; it needs release then press.
- Reset (rst low, asynchronous):
  - color=0, in_play=0.
  - All pipeline registers, flash_cnt and key_q cleared.
  - Reset mid-frame: output resumes valid 2 clk after release. No flash is pending.
- Edge cases:
  - x>XE or x<X0 goes to background even on judgement rows.
  - y>=TRACK_H never reads the bitmap; it yields track colour.

Optional Feature:
- LANE_PALETTE_EN:
  - Defined: note colour is 12'hF00 for even lanes and 12'h00F for odd lanes.
  - Undefined: all notes are 12'hF00.
- Geometry and timing are identical in both builds.

Test Plan:
- Reset held, any x/y → color=000, in_play=0. Release, x=60,y=100, keys=0 → color=000 two clks later, in_play=1.
- Borders (defaults): x=50/55/156/161/474/479 any y → FFF. x=49 and x=480 with bg_active=1, bg_color=ABC → ABC. bg_active=0 → 000.
- Notes: tracks bit 200 of lane 1 set; x=162,y=200 → F00 (00F with LANE_PALETTE_EN). y=201 → 000. keys[1]=1, y=201 → 777. Note at y=442 is ignored (judgement line FFF).
- Flash:
  - Press keys[2] at x=300,y=460 → 0FF.
  - 8 frame_ticks → 777 while held. Release → 444.
  - Rise coinciding with frame_tick → counter=8.
- Latency: sweep x 0..639 on row 100 and check each color appears exactly 2 clk after its x.
- NUM_LANES=7, LANE_W=60, BORDER_W=4 → XE=50+7*64+3=501. x=501 → FFF. x=502 → background.
